// File: rtl/transmitter.sv
// transmitter
//   UART transmit stage. Pops bytes from the transmit FIFO and sends each one
//   as an 8N1 or 8N2 frame on TX_PIN, LSB first. The bit period is CPB clocks,
//   taken from the receiver's autobaud. Nothing is sent while CPB is 0.
//
// Ports
//   CLK      system clock, all logic on posedge
//   RESETn   asynchronous active-low reset
//   CPB      clocks per bit from the receiver, 0 = baud not yet known
//   RDDATA   FIFO read data, valid the cycle after an RDEN cycle
//   RDEN     FIFO pop strobe, one cycle per byte
//   RDEMPTY  FIFO empty flag
//   TX_PIN   serial output, idle high, registered
//   BUSY     high while a frame is in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, waiting for a byte and a known baud rate
// FETCH | popped byte arrives: load shift reg, latch CPB, drive start bit
// START | start bit (low) held for cpb_l clocks
// DATA  | eight data bits, cpb_l clocks each, LSB first
// STOP  | line high for STOP_BITS * cpb_l clocks
module transmitter #(
   parameter int CPB_WIDTH = 12,
   parameter int STOP_BITS = 1
) (
   input  logic                 CLK,
   input  logic                 RESETn,
   input  logic [CPB_WIDTH-1:0] CPB,
   input  logic [7:0]           RDDATA,
   output logic                 RDEN,
   input  logic                 RDEMPTY,
   output logic                 TX_PIN,
   output logic                 BUSY
);

   // One extra bit so the stop period of two bit times always fits.
   localparam int CW = CPB_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t               state;
   logic [CW-1:0]        ctr;
   logic [CPB_WIDTH-1:0] cpb_l;
   logic [7:0]           sr;
   logic [2:0]           bcnt;

   logic [CW-1:0]        bit_last;
   logic [CW-1:0]        stop_last;

   // cpb_l is never 0 outside IDLE/FETCH, so these never underflow where used.
   assign bit_last  = {1'b0, cpb_l} - CW'(1);
   assign stop_last = (CW'(STOP_BITS) * {1'b0, cpb_l}) - CW'(1);

   // Pop is combinational so the byte is on RDDATA exactly in FETCH.
   assign RDEN = RESETn & (state == IDLE) & ~RDEMPTY & (CPB != '0);
   assign BUSY = (state != IDLE);

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state  <= IDLE;
         TX_PIN <= 1'b1;
         ctr    <= '0;
         cpb_l  <= '0;
         sr     <= '0;
         bcnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               TX_PIN <= 1'b1;
               if (RDEN) state <= FETCH;
            end

            FETCH: begin
               sr     <= RDDATA;
               cpb_l  <= CPB;
               ctr    <= '0;
               TX_PIN <= 1'b0;
               state  <= START;
            end

            START: begin
               if (ctr == bit_last) begin
                  ctr    <= '0;
                  TX_PIN <= sr[0];
                  bcnt   <= '0;
                  state  <= DATA;
               end else begin
                  ctr <= ctr + CW'(1);
               end
            end

            DATA: begin
               if (ctr == bit_last) begin
                  ctr <= '0;
                  if (bcnt == 3'd7) begin
                     TX_PIN <= 1'b1;
                     state  <= STOP;
                  end else begin
                     // sr[1] is the next bit before the shift takes effect.
                     sr     <= {1'b0, sr[7:1]};
                     TX_PIN <= sr[1];
                     bcnt   <= bcnt + 3'd1;
                  end
               end else begin
                  ctr <= ctr + CW'(1);
               end
            end

            STOP: begin
               TX_PIN <= 1'b1;
               if (ctr == stop_last) begin
                  ctr   <= '0;
                  state <= IDLE;
               end else begin
                  ctr <= ctr + CW'(1);
               end
            end

            default: begin
               TX_PIN <= 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
